// File: rtl/mux_scan_sequencer_if.sv
// Signal bundle between the mux scan sequencer and its environment.
// The master drives pins and mode controls; the slave (the sequencer) drives the mux side.
interface mux_scan_sequencer_if;
   logic [3:0] raw_in;
   logic [1:0] man_sel;
   logic       auto_en;
   logic [1:0] sel;
   logic [3:0] data_out;
   logic       dwell_done;
   logic       scan_wrap;

   modport master (
      output raw_in, man_sel, auto_en,
      input  sel, data_out, dwell_done, scan_wrap
   );

   modport slave (
      input  raw_in, man_sel, auto_en,
      output sel, data_out, dwell_done, scan_wrap
   );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Feeder for a 4:1 output mux: synchronises and debounces four pins, generates the
// channel select (auto-scan or manual) and flags when the selected output has settled.
module mux_scan_sequencer #(
   parameter int DWELL_CYCLES = 8,
   parameter int DB_CYCLES    = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   mux_scan_sequencer_if.slave   seq_if
);

   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int DWW = $clog2(DWELL_CYCLES);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
   localparam logic [DWW-1:0] DW_LAST = DWW'(DWELL_CYCLES - 1);
   localparam logic [DWW-1:0] DW_PRE  = DWW'(DWELL_CYCLES - 2);

   typedef enum logic {MANUAL, SCAN} state_e;

   logic [3:0]     sync_q [SYNC_STAGES];
   logic [3:0]     synced;
   logic [3:0]     data_q, data_d;
   logic [DBW-1:0] db_cnt_q [4];
   logic [DBW-1:0] db_cnt_d [4];

   state_e         state_q;
   logic [1:0]     sel_q;
   logic [DWW-1:0] dw_cnt_q;
   logic           dwell_q;
   logic           wrap_q;

   assign synced = sync_q[SYNC_STAGES-1];

   // A bit is accepted once it has differed from data_out on DB_CYCLES consecutive edges.
   always_comb begin
      data_d = data_q;
      for (int i = 0; i < 4; i++) begin
         db_cnt_d[i] = '0;
         if (synced[i] != data_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               data_d[i] = synced[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
         data_q <= '0;
      end else begin
         sync_q[0] <= seq_if.raw_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
         data_q <= data_d;
      end
   end

   // dwell_done/scan_wrap are raised on the edge where the counter becomes DWELL_CYCLES-1,
   // so they are visible while sel still points at the settled channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MANUAL;
         sel_q    <= '0;
         dw_cnt_q <= '0;
         dwell_q  <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         dwell_q <= 1'b0;
         wrap_q  <= 1'b0;
         case (state_q)
            MANUAL: begin
               if (seq_if.auto_en) begin
                  state_q  <= SCAN;
                  sel_q    <= '0;
                  dw_cnt_q <= '0;
               end else if (seq_if.man_sel != sel_q) begin
                  sel_q    <= seq_if.man_sel;
                  dw_cnt_q <= '0;
               end else if (dw_cnt_q != DW_LAST) begin
                  dw_cnt_q <= dw_cnt_q + DWW'(1);
                  dwell_q  <= (dw_cnt_q == DW_PRE);
               end
            end
            SCAN: begin
               if (!seq_if.auto_en) begin
                  state_q  <= MANUAL;
                  sel_q    <= seq_if.man_sel;
                  dw_cnt_q <= '0;
               end else if (dw_cnt_q == DW_LAST) begin
                  sel_q    <= sel_q + 2'd1;
                  dw_cnt_q <= '0;
               end else begin
                  dw_cnt_q <= dw_cnt_q + DWW'(1);
                  if (dw_cnt_q == DW_PRE) begin
                     dwell_q <= 1'b1;
                     wrap_q  <= (sel_q == 2'd3);
                  end
               end
            end
            default: state_q <= MANUAL;
         endcase
      end
   end

   assign seq_if.sel        = sel_q;
   assign seq_if.data_out   = data_q;
   assign seq_if.dwell_done = dwell_q;
   assign seq_if.scan_wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer (DWELL_CYCLES=8, DB_CYCLES=4, SYNC_STAGES=2).
module tb_mux_scan_sequencer;

   logic clk;
   logic rst;

   mux_scan_sequencer_if bus();

   mux_scan_sequencer #(
      .DWELL_CYCLES(8),
      .DB_CYCLES   (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .seq_if(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       auto_en;
      logic [1:0] man_sel;
      logic [3:0] raw;
      logic [7:0] exp;   // {sel, data_out, dwell_done, scan_wrap}
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] obs();
      return {bus.sel, bus.data_out, bus.dwell_done, bus.scan_wrap};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic ae, input logic [1:0] ms, input logic [3:0] raw,
                      input logic [1:0] es, input logic [3:0] ed, input logic edw, input logic ewr);
      vec_t v;
      v.rst     = r;
      v.auto_en = ae;
      v.man_sel = ms;
      v.raw     = raw;
      v.exp     = {es, ed, edw, ewr};
      vecs.push_back(v);
   endtask

   initial begin
      logic [3:0] pat;
      logic [1:0] es;
      logic       edw, ewr, saw_low, stayed;

      // Reset, then manual select 2 (single dwell pulse, no repeat), then 1 (dwell restarts).
      add(1, 0, 2'd0, 4'h0, 2'd0, 4'h0, 0, 0);
      add(1, 0, 2'd0, 4'h0, 2'd0, 4'h0, 0, 0);
      add(0, 0, 2'd2, 4'h0, 2'd2, 4'h0, 0, 0);
      for (int i = 0; i < 6; i++) add(0, 0, 2'd2, 4'h0, 2'd2, 4'h0, 0, 0);
      add(0, 0, 2'd2, 4'h0, 2'd2, 4'h0, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 2'd2, 4'h0, 2'd2, 4'h0, 0, 0);
      add(0, 0, 2'd1, 4'h0, 2'd1, 4'h0, 0, 0);
      for (int i = 0; i < 6; i++) add(0, 0, 2'd1, 4'h0, 2'd1, 4'h0, 0, 0);
      add(0, 0, 2'd1, 4'h0, 2'd1, 4'h0, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 2'd1, 4'h0, 2'd1, 4'h0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst         = vecs[i].rst;
         bus.auto_en = vecs[i].auto_en;
         bus.man_sel = vecs[i].man_sel;
         bus.raw_in  = vecs[i].raw;
         tick();
         check($sformatf("vec%0d", i), obs(), vecs[i].exp);
      end

      // Debounce latency: raw edge reaches data_out exactly 6 edges later.
      bus.raw_in = 4'b0100;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("latency_e%0d", k), {4'h0, bus.data_out}, (k == 6) ? 8'h04 : 8'h00);
      end

      // 3-cycle low glitch is rejected.
      bus.raw_in = 4'b0000;
      repeat (3) tick();
      bus.raw_in = 4'b0100;
      stayed = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bus.data_out !== 4'b0100) stayed = 1'b0;
      end
      check("glitch3_rejected", {7'd0, stayed}, 8'd1);

      // 4-cycle low glitch is long enough to pass, then recovers.
      bus.raw_in = 4'b0000;
      repeat (4) tick();
      bus.raw_in = 4'b0100;
      saw_low = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus.data_out[2] === 1'b0) saw_low = 1'b1;
      end
      check("glitch4_passes", {7'd0, saw_low}, 8'd1);
      check("glitch4_recovers", {4'h0, bus.data_out}, 8'h04);

      // Settle the mux pattern, then auto-scan.
      pat        = 4'b1010;
      bus.raw_in = pat;
      repeat (10) tick();
      check("pattern_settled", {4'h0, bus.data_out}, {4'h0, pat});

      bus.auto_en = 1'b1;
      for (int k = 0; k < 63; k++) begin
         tick();
         es  = 2'((k / 8) % 4);
         edw = ((k % 8) == 7);
         ewr = (k == 31);
         check($sformatf("scan_k%0d", k), obs(), {es, pat, edw, ewr});
         if (edw) check($sformatf("mux_sel%0d", es), {7'd0, bus.data_out[bus.sel]}, {7'd0, pat[es]});
      end

      // Abort on the edge that would end the sel=3 dwell: no pulse, no wrap, sel follows man_sel.
      bus.auto_en = 1'b0;
      bus.man_sel = 2'd2;
      tick();
      check("abort", obs(), {2'd2, pat, 1'b0, 1'b0});
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("abort_settle%0d", k), obs(), {2'd2, pat, 1'b0, 1'b0});
      end
      tick();
      check("abort_dwell", obs(), {2'd2, pat, 1'b1, 1'b0});

      // Reset mid-scan with all data bits high.
      bus.raw_in  = 4'hF;
      bus.auto_en = 1'b1;
      repeat (12) tick();
      check("pre_reset_data", {4'h0, bus.data_out}, 8'h0F);
      rst = 1'b1;
      tick();
      check("reset_e1", obs(), 8'h00);
      tick();
      check("reset_e2", obs(), 8'h00);
      rst         = 1'b0;
      bus.raw_in  = 4'h0;
      bus.auto_en = 1'b0;
      bus.man_sel = 2'd3;
      tick();
      check("post_reset_sel", obs(), {2'd3, 4'h0, 1'b0, 1'b0});
      stayed = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.data_out !== 4'h0) stayed = 1'b0;
      end
      check("post_reset_data_clear", {7'd0, stayed}, 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
